// File: rtl/i2c_target_pkg.sv
// ---------------------------------------------------------------------------
// i2c_target_pkg
// Shared definitions for the I2C target: controller state encoding and the
// protocol bit constants (ACK/NACK level, R/W direction bit).
// ---------------------------------------------------------------------------
package i2c_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_IGNORE
    } state_t;

    // Bus level in the acknowledge slot.
    localparam logic BIT_ACK  = 1'b0;
    localparam logic BIT_NACK = 1'b1;

    // Direction bit following the 7-bit address.
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Brings SCL/SDA into the clk_12MHz domain (2-FF synchronizer each) and keeps
// one history flop per line to derive bus events.
//   clk_12MHz, reset : system clock, synchronous active-high reset
//   scl, sda         : raw bus lines
//   scl_rise/fall    : one-cycle SCL edge events
//   sda_s            : synchronized SDA level
//   start_det        : SDA fell while SCL high
//   stop_det         : SDA rose while SCL high
// ---------------------------------------------------------------------------
module i2c_bus_sync (
    input  logic clk_12MHz,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_meta;
    logic [1:0] sda_meta;
    logic       scl_prev;
    logic       sda_prev;
    logic       scl_s;

    // Reset to the idle-bus level (both lines high) so leaving reset never
    // fabricates an edge on a quiet bus.
    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            scl_meta <= 2'b11;
            sda_meta <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so the chain shifts by exactly one stage per clock.
            scl_meta <= {scl_meta[0], scl};
            sda_meta <= {sda_meta[0], sda};
            scl_prev <= scl_meta[1];
            sda_prev <= sda_meta[1];
        end
    end

    assign scl_s     = scl_meta[1];
    assign sda_s     = sda_meta[1];
    assign scl_rise  =  scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s &  scl_prev;
    // Require SCL high on both sides of the SDA edge.
    assign start_det =  scl_s & scl_prev &  sda_prev & ~sda_s;
    assign stop_det  =  scl_s & scl_prev & ~sda_prev &  sda_s;

endmodule

// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
// I2C target answering one 7-bit address. Written bytes are delivered on
// rx_data/rx_valid; read bytes are fetched through tx_req/tx_data. No clock
// stretching; the bus is oversampled by clk_12MHz.
//   address   : own 7-bit target address (parameter)
//   clk_12MHz : system clock, reset : synchronous active-high reset
//   sda       : open-drain data line (driven 0 or z), scl : clock input
//   rx_data/rx_valid/rx_first : received byte, update pulse, first-byte tag
//   tx_req/tx_data : next-read-byte request pulse and same-cycle byte
//   addressed : high from address ACK until next START/STOP
//   stop_seen : one-cycle pulse on STOP
// ---------------------------------------------------------------------------
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] address = 7'h42
) (
    input  logic       clk_12MHz,
    input  logic       reset,
    inout  wire        sda,
    input  logic       scl,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       addressed,
    output logic       stop_seen
);

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk_12MHz (clk_12MHz),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_low_q, sda_low_d;
    logic       addressed_q, addressed_d;
    logic       first_q, first_d;      // next RX byte is the first after address
    logic       read_q, read_d;        // current transfer is a read
    logic       tx_pend_q, tx_pend_d;  // master ACKed, next byte latched
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_d, rx_first_d, stop_seen_d;
    logic       rx_valid_q, rx_first_q, stop_seen_q;
    logic       tx_req_c;
    logic       bit_done;
    logic [7:0] shift_in;

    // Counter sits on the last bit of the byte; the increment wraps to 0.
    assign bit_done = (bit_cnt_q == 3'd7);
    assign shift_in = {shift_q[6:0], sda_s};

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            sda_low_q   <= 1'b0;
            addressed_q <= 1'b0;
            first_q     <= 1'b0;
            read_q      <= 1'b0;
            tx_pend_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            stop_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sda_low_q   <= sda_low_d;
            addressed_q <= addressed_d;
            first_q     <= first_d;
            read_q      <= read_d;
            tx_pend_q   <= tx_pend_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_first_q  <= rx_first_d;
            stop_seen_q <= stop_seen_d;
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sda_low_d   = sda_low_q;
        addressed_d = addressed_q;
        first_d     = first_q;
        read_d      = read_q;
        tx_pend_d   = tx_pend_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_first_d  = 1'b0;
        stop_seen_d = 1'b0;
        tx_req_c    = 1'b0;

        if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = '0;
            sda_low_d   = 1'b0;
            addressed_d = 1'b0;
            first_d     = 1'b0;
            tx_pend_d   = 1'b0;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            sda_low_d   = 1'b0;
            addressed_d = 1'b0;
            first_d     = 1'b0;
            tx_pend_d   = 1'b0;
            stop_seen_d = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_done) begin
                            if (shift_in[7:1] == address) begin
                                state_d = ST_ADDR_ACK;
                                case (shift_in[0])
                                    RW_READ: begin
                                        read_d   = 1'b1;
                                        tx_req_c = 1'b1;
                                        shift_d  = tx_data;
                                    end
                                    RW_WRITE: begin
                                        read_d  = 1'b0;
                                        first_d = 1'b1;
                                    end
                                endcase
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end

                // sda_low_q doubles as the phase flag: 0 = ACK not yet driven.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_d   = 1'b1;
                            addressed_d = 1'b1;
                        end else if (read_q) begin
                            sda_low_d = ~shift_q[7];
                            state_d   = ST_TX;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = ST_RX;
                        end
                    end
                end

                ST_RX: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_done) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                            state_d    = ST_RX_ACK;
                        end
                    end
                end

                ST_RX_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_d = 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = ST_RX;
                        end
                    end
                end

                // Bit 7 is already on the bus at entry; each fall presents the
                // next bit, and the fall after bit 0 releases the line.
                ST_TX: begin
                    if (scl_fall) begin
                        if (bit_done) begin
                            sda_low_d = 1'b0;
                            state_d   = ST_TX_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_low_d = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end

                ST_TX_ACK: begin
                    if (scl_rise) begin
                        case (sda_s)
                            BIT_ACK: begin
                                tx_req_c  = 1'b1;
                                shift_d   = tx_data;
                                tx_pend_d = 1'b1;
                            end
                            BIT_NACK: begin
                                state_d = ST_IGNORE;
                            end
                        endcase
                    end else if (scl_fall && tx_pend_q) begin
                        sda_low_d = ~shift_q[7];
                        tx_pend_d = 1'b0;
                        state_d   = ST_TX;
                    end
                end

                default: ;  // IDLE, IGNORE: wait for START/STOP
            endcase
        end

        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end
    end

    assign sda       = sda_low_q ? 1'b0 : 1'bz;
    assign tx_req    = tx_req_c & ~reset;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_first  = rx_first_q;
    assign addressed = addressed_q;
    assign stop_seen = stop_seen_q;

endmodule

// File: tb/tb_i2c_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_target
// Bit-banged I2C controller driving i2c_target. Expected DUT pulses
// (rx_valid, tx_req, stop_seen) are queued by the stimulus and consumed by a
// negedge monitor; bus-level results (ACK bits, read bytes) are checked inline.
// ---------------------------------------------------------------------------
module tb_i2c_target;

    logic       clk_12MHz = 1'b0;
    logic       reset     = 1'b1;
    logic       scl       = 1'b1;
    logic       m_low     = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first, tx_req, addressed, stop_seen;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #42 clk_12MHz = ~clk_12MHz;

    i2c_target #(.address(7'h42)) dut (
        .clk_12MHz (clk_12MHz),
        .reset     (reset),
        .sda       (sda),
        .scl       (scl),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_first  (rx_first),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .addressed (addressed),
        .stop_seen (stop_seen)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] data;
        logic       first;
    } rx_exp_t;

    rx_exp_t    exp_rx[$];
    logic [7:0] exp_tx[$];
    int         exp_stop[$];
    rx_exp_t    mon_rx;
    logic [7:0] mon_tx;
    int         mon_stop;

    always @(negedge clk_12MHz) begin
        if (rx_valid) begin
            check("rx_valid expected", 32'(exp_rx.size() > 0), 1);
            if (exp_rx.size() > 0) begin
                mon_rx = exp_rx.pop_front();
                check("rx_data", rx_data, mon_rx.data);
                check("rx_first", rx_first, mon_rx.first);
            end
        end else if (rx_first) begin
            check("rx_first without rx_valid", rx_first, rx_valid);
        end
        if (tx_req) begin
            check("tx_req expected", 32'(exp_tx.size() > 0), 1);
            if (exp_tx.size() > 0) begin
                mon_tx = exp_tx.pop_front();
                check("tx_data at tx_req", tx_data, mon_tx);
            end
        end
        if (stop_seen) begin
            check("stop_seen expected", 32'(exp_stop.size() > 0), 1);
            if (exp_stop.size() > 0) mon_stop = exp_stop.pop_front();
        end
    end

    // ---------------- bus master ----------------
    task automatic qwait();
        repeat (10) @(negedge clk_12MHz);
    endtask

    // Also serves as repeated START: releases SDA with SCL low first.
    task automatic bus_start();
        m_low = 1'b0; qwait();
        scl   = 1'b1; qwait();
        m_low = 1'b1; qwait();
        scl   = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        m_low = 1'b1; qwait();
        scl   = 1'b1; qwait();
        m_low = 1'b0; qwait();
    endtask

    task automatic bus_bit(input logic b, output logic r);
        m_low = ~b;   qwait();
        scl   = 1'b1; qwait();
        r     = sda;  qwait();
        scl   = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_lvl, input logic [7:0] next_tx,
                             output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            b[i] = r;
        end
        tx_data = next_tx;
        bus_bit(ack_lvl, r);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       ack;
        logic       r;
        logic [7:0] rd;
        logic [7:0] abyte;

        repeat (5) @(negedge clk_12MHz);
        reset = 1'b0;
        @(negedge clk_12MHz);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_first", rx_first, 0);
        check("reset tx_req", tx_req, 0);
        check("reset addressed", addressed, 0);
        check("reset stop_seen", stop_seen, 0);
        check("reset sda released", sda, 1);

        // 1) write 0xA5, 0x3C
        exp_rx.push_back('{data: 8'hA5, first: 1'b1});
        exp_rx.push_back('{data: 8'h3C, first: 1'b0});
        exp_stop.push_back(1);
        bus_start();
        write_byte(8'h84, ack); check("wr addr ack", ack, 0);
        check("wr addressed", addressed, 1);
        write_byte(8'hA5, ack); check("wr A5 ack", ack, 0);
        write_byte(8'h3C, ack); check("wr 3C ack", ack, 0);
        bus_stop();
        check("wr addressed after stop", addressed, 0);
        check("wr rx_data held", rx_data, 8'h3C);

        // 2) read 0x5A (ACK), 0xC3 (NACK)
        tx_data = 8'h5A;
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'hC3);
        exp_stop.push_back(1);
        bus_start();
        write_byte(8'h85, ack); check("rd addr ack", ack, 0);
        read_byte(1'b0, 8'hC3, rd); check("rd byte0", rd, 8'h5A);
        read_byte(1'b1, 8'h00, rd); check("rd byte1", rd, 8'hC3);
        check("rd sda released after nack", sda, 1);
        bus_stop();

        // 3) non-matching address 0x90
        exp_stop.push_back(1);
        bus_start();
        write_byte(8'h90, ack); check("nomatch ack slot high", ack, 1);
        check("nomatch addressed", addressed, 0);
        bus_stop();

        // 4) write 0x10, repeated START, read 0x77
        tx_data = 8'h77;
        exp_rx.push_back('{data: 8'h10, first: 1'b1});
        exp_tx.push_back(8'h77);
        exp_stop.push_back(1);
        bus_start();
        write_byte(8'h84, ack); check("rs wr addr ack", ack, 0);
        write_byte(8'h10, ack); check("rs 10 ack", ack, 0);
        bus_start();
        write_byte(8'h85, ack); check("rs rd addr ack", ack, 0);
        read_byte(1'b1, 8'h00, rd); check("rs rd byte", rd, 8'h77);
        bus_stop();
        check("rs rx_data", rx_data, 8'h10);

        // 5) START in the 4th bit of a data byte
        exp_rx.push_back('{data: 8'h55, first: 1'b1});
        exp_stop.push_back(1);
        bus_start();
        write_byte(8'h84, ack); check("mid addr ack", ack, 0);
        bus_bit(1'b1, r); bus_bit(1'b0, r); bus_bit(1'b1, r);
        m_low = 1'b0; qwait();
        scl   = 1'b1; qwait();
        m_low = 1'b1; qwait();     // SDA falls with SCL high: START
        scl   = 1'b0; qwait();
        check("mid addressed cleared", addressed, 0);
        write_byte(8'h84, ack); check("mid re-addr ack", ack, 0);
        write_byte(8'h55, ack); check("mid 55 ack", ack, 0);
        bus_stop();

        // 6) reset while the target drives the address ACK
        abyte = 8'h84;
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(abyte[i], r);
        m_low = 1'b0; qwait();
        scl   = 1'b1; qwait();
        check("rst ack driven", sda, 0);
        check("rst addressed before", addressed, 1);
        reset = 1'b1;
        @(posedge clk_12MHz); #1;
        check("rst sda released", sda, 1);
        check("rst rx_data", rx_data, 0);
        check("rst addressed", addressed, 0);
        check("rst rx_valid", rx_valid, 0);
        check("rst rx_first", rx_first, 0);
        check("rst tx_req", tx_req, 0);
        check("rst stop_seen", stop_seen, 0);
        @(negedge clk_12MHz);
        reset = 1'b0;
        qwait();
        scl = 1'b0; qwait();
        exp_stop.push_back(1);
        bus_stop();

        exp_rx.push_back('{data: 8'h99, first: 1'b1});
        exp_stop.push_back(1);
        bus_start();
        write_byte(8'h84, ack); check("post-rst addr ack", ack, 0);
        write_byte(8'h99, ack); check("post-rst 99 ack", ack, 0);
        bus_stop();
        check("post-rst rx_data", rx_data, 8'h99);

        repeat (20) @(negedge clk_12MHz);
        check("rx_valid pulses outstanding", exp_rx.size(), 0);
        check("tx_req pulses outstanding", exp_tx.size(), 0);
        check("stop_seen pulses outstanding", exp_stop.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
